// File: rtl/mcs4_clk_rst_gen_if.sv
// Output bundle of the MCS-4 clock/reset generator, plus the raw pad clear that feeds it.
interface mcs4_clk_rst_gen_if;
    logic       clear_in;
    logic       clk1;
    logic       clk2;
    logic       sync;
    logic [2:0] subcycle;
    logic       core_reset;

    modport master (
        input  clear_in,
        output clk1, clk2, sync, subcycle, core_reset
    );

    modport slave (
        output clear_in,
        input  clk1, clk2, sync, subcycle, core_reset
    );
endinterface

// File: rtl/mcs4_clk_rst_gen.sv
// Two-phase clock enables, 8-subcycle frame with SYNC, and a debounced,
// frame-aligned core reset held for RESET_CYCLES instruction cycles.
module mcs4_clk_rst_gen #(
    parameter int DEBOUNCE     = 16,
    parameter int RESET_CYCLES = 8
) (
    input  logic                   i_sysclk,
    input  logic                   i_poc,
    mcs4_clk_rst_gen_if.master     bus
);

    localparam int DB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    typedef enum logic {
        S_HOLD = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // ---------------- phase / subcycle frame ----------------
    logic       r_started;
    logic [1:0] r_ph;
    logic [2:0] r_sub;
    logic       r_clk1;
    logic       r_clk2;
    logic       r_sync;
    logic [1:0] w_ph_nxt;
    logic [2:0] w_sub_nxt;
    logic       w_wrap;

    // The first edge after poc presents A1/phase 0 without advancing.
    always_comb begin
        w_ph_nxt  = r_ph;
        w_sub_nxt = r_sub;
        if (r_started) begin
            w_ph_nxt = r_ph + 2'd1;
            if (r_ph == 2'd3) begin
                w_sub_nxt = r_sub + 3'd1;
            end
        end
    end

    assign w_wrap = r_started && (r_ph == 2'd3) && (r_sub == 3'd7);

    always_ff @(posedge i_sysclk) begin
        if (i_poc) begin
            r_started <= 1'b0;
            r_ph      <= 2'd0;
            r_sub     <= 3'd0;
            r_clk1    <= 1'b0;
            r_clk2    <= 1'b0;
            r_sync    <= 1'b0;
        end else begin
            r_started <= 1'b1;
            r_ph      <= w_ph_nxt;
            r_sub     <= w_sub_nxt;
            r_clk1    <= (w_ph_nxt == 2'd0);
            r_clk2    <= (w_ph_nxt == 2'd2);
            r_sync    <= (w_sub_nxt == 3'd7);
        end
    end

    // ---------------- clear synchronizer and debounce ----------------
    logic            r_sync1;
    logic            r_sync2;
    logic [DB_W-1:0] r_db_cnt;
    logic            r_clr_db;
    logic            w_db_flip;
    logic            w_db_rise;

    assign w_db_flip = (r_sync2 != r_clr_db) && (r_db_cnt == DB_W'(DEBOUNCE - 1));
    assign w_db_rise = w_db_flip && r_sync2;

    always_ff @(posedge i_sysclk) begin
        if (i_poc) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_db_cnt <= '0;
            r_clr_db <= 1'b0;
        end else begin
            r_sync1 <= bus.clear_in;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_clr_db) begin
                r_db_cnt <= '0;
            end else if (w_db_flip) begin
                r_clr_db <= r_sync2;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + DB_W'(1);
            end
        end
    end

    // ---------------- reset FSM ----------------
    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_rc;
    logic [7:0] w_rc_nxt;
    logic       r_armed;
    logic       w_armed_nxt;
    logic       r_core_reset;

    // r_armed marks that a full instruction cycle is now being counted; the
    // cycle in progress when the debounced clear drops is skipped.
    always_comb begin
        w_state_nxt = r_state;
        w_rc_nxt    = r_rc;
        w_armed_nxt = r_armed;
        case (r_state)
            S_HOLD: begin
                if (r_clr_db || w_db_rise) begin
                    w_rc_nxt    = 8'd0;
                    w_armed_nxt = 1'b0;
                end else if (w_wrap) begin
                    if (!r_armed) begin
                        w_armed_nxt = 1'b1;
                    end else if (({1'b0, r_rc} + 9'd1) == 9'(RESET_CYCLES)) begin
                        w_state_nxt = S_RUN;
                        w_rc_nxt    = 8'd0;
                    end else begin
                        w_rc_nxt = r_rc + 8'd1;
                    end
                end
            end
            S_RUN: begin
                if (w_db_rise) begin
                    w_state_nxt = S_HOLD;
                    w_rc_nxt    = 8'd0;
                    w_armed_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = S_HOLD;
                w_rc_nxt    = 8'd0;
                w_armed_nxt = 1'b0;
            end
        endcase
    end

    // After poc the first A1 (edge 1) already starts a counted cycle.
    always_ff @(posedge i_sysclk) begin
        if (i_poc) begin
            r_state      <= S_HOLD;
            r_rc         <= 8'd0;
            r_armed      <= 1'b1;
            r_core_reset <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_rc         <= w_rc_nxt;
            r_armed      <= w_armed_nxt;
            r_core_reset <= (w_state_nxt == S_HOLD);
        end
    end

    assign bus.clk1       = r_clk1;
    assign bus.clk2       = r_clk2;
    assign bus.sync       = r_sync;
    assign bus.subcycle   = r_sub;
    assign bus.core_reset = r_core_reset;

endmodule

// File: tb/tb_mcs4_clk_rst_gen.sv
// Bench for mcs4_clk_rst_gen: edge-indexed behavioural model plus directed literal checkpoints.
module tb_mcs4_clk_rst_gen;

    localparam int DB = 16;
    localparam int RC = 8;

    logic clk;
    logic poc;
    int   n_checks;
    int   n_err;
    int   e;

    mcs4_clk_rst_gen_if bus_if ();

    mcs4_clk_rst_gen #(
        .DEBOUNCE     (DB),
        .RESET_CYCLES (RC)
    ) dut (
        .i_sysclk (clk),
        .i_poc    (poc),
        .bus      (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] outs();
        return {bus_if.clk1, bus_if.clk2, bus_if.sync, bus_if.subcycle, bus_if.core_reset};
    endfunction

    // Model: everything is a function of the edge index k since poc release
    // and of the debounced clear history.
    int m_k;
    int m_run;
    int m_rel;
    bit m_s1;
    bit m_s2;
    bit m_db;
    bit m_old;
    bit m_cr;
    logic [6:0] m_exp;

    function automatic int next_boundary(input int k);
        return 1 + 32 * ((k - 1) / 32 + 1);
    endfunction

    always @(posedge clk) begin
        if (poc) begin
            m_k   = 0;
            m_s1  = 1'b0;
            m_s2  = 1'b0;
            m_db  = 1'b0;
            m_run = 0;
            m_cr  = 1'b1;
            m_rel = 1 + 32 * RC;
        end else begin
            m_k++;
            m_old = m_db;
            if (m_s2 != m_db) begin
                m_run++;
                if (m_run == DB) begin
                    m_db  = m_s2;
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end
            m_s2 = m_s1;
            m_s1 = bus_if.clear_in;
            if (m_db && !m_old) begin
                m_cr  = 1'b1;
                m_rel = -1;
            end else if (!m_db && m_old) begin
                m_rel = next_boundary(m_k) + 32 * RC;
            end else if (!m_db && m_k == m_rel) begin
                m_cr = 1'b0;
            end
        end
        if (m_k >= 1) begin
            m_exp = {((m_k - 1) % 4 == 0), ((m_k - 1) % 4 == 2),
                     (((m_k - 1) / 4) % 8 == 7), 3'(((m_k - 1) / 4) % 8), m_cr};
        end else begin
            m_exp = {6'b000000, m_cr};
        end
        #1;
        chk("model_outputs", 32'(outs()), 32'(m_exp));
        if (bus_if.clk1 && bus_if.clk2) begin
            chk("clk_overlap", 32'(1), 32'(0));
        end
    end

    task automatic adv(input int n);
        repeat (n) begin
            @(negedge clk);
            e++;
        end
    endtask

    task automatic goto(input int t);
        if (t > e) adv(t - e);
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        e        = 0;
        poc      = 1'b1;
        bus_if.clear_in = 1'b0;
        repeat (5) @(negedge clk);
        chk("reset_vals", 32'(outs()), 32'(7'b0000001));

        poc = 1'b0;
        e   = 0;
        goto(1);   chk("edge1", 32'(outs()), 32'(7'b1000001));
        goto(2);   chk("edge2", 32'(outs()), 32'(7'b0000001));
        goto(3);   chk("edge3", 32'(outs()), 32'(7'b0100001));
        goto(28);  chk("sync_e28", 32'(bus_if.sync), 32'(0));
        goto(29);  chk("edge29", 32'(outs()), 32'(7'b1011111));
        goto(32);  chk("sync_e32", 32'(bus_if.sync), 32'(1));
        goto(33);  chk("edge33", 32'(outs()), 32'(7'b1000001));
        goto(256); chk("rst_e256", 32'(bus_if.core_reset), 32'(1));
        goto(257); chk("edge257", 32'(outs()), 32'(7'b1000000));

        // 10-tick glitch must be filtered
        goto(300); bus_if.clear_in = 1'b1;
        adv(10);   bus_if.clear_in = 1'b0;
        goto(330); chk("glitch_rst", 32'(bus_if.core_reset), 32'(0));

        // valid 40-tick clear: rise at +18, release at 9th A1 after db fall (458 -> 481 -> 737)
        goto(400); bus_if.clear_in = 1'b1;
        goto(417); chk("clr_e417", 32'(bus_if.core_reset), 32'(0));
        goto(418); chk("clr_e418", 32'(bus_if.core_reset), 32'(1));
        goto(440); bus_if.clear_in = 1'b0;
        goto(736); chk("rel_e736", 32'(bus_if.core_reset), 32'(1));
        goto(737); chk("rel_e737", 32'(bus_if.core_reset), 32'(0));

        // clear, then reassert mid-countdown: old end 1089 must not release, new end 1217
        goto(760); bus_if.clear_in = 1'b1;
        goto(790); bus_if.clear_in = 1'b0;
        goto(900); bus_if.clear_in = 1'b1;
        goto(930); bus_if.clear_in = 1'b0;
        goto(1089); chk("reassert_e1089", 32'(bus_if.core_reset), 32'(1));
        goto(1216); chk("reassert_e1216", 32'(bus_if.core_reset), 32'(1));
        goto(1217); chk("reassert_e1217", 32'(bus_if.core_reset), 32'(0));

        // poc pulse while subcycle = 5
        goto(1237); chk("sub_before_poc", 32'(bus_if.subcycle), 32'(5));
        poc = 1'b1;
        adv(1);    chk("poc_mid_vals", 32'(outs()), 32'(7'b0000001));
        poc = 1'b0;
        e   = 0;
        goto(1);   chk("poc_edge1", 32'(outs()), 32'(7'b1000001));
        goto(256); chk("poc_e256", 32'(bus_if.core_reset), 32'(1));
        goto(257); chk("poc_e257", 32'(outs()), 32'(7'b1000000));
        goto(300);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
